// File: rtl/conv_result_collector.sv
// Collects finished DSP accumulations from the allocators round-robin, then rescales, clamps and
// saturates each one and writes it to output image memory. Grant-to-write latency is two cycles.
module conv_result_collector #(
    parameter int num_allocators = 220
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [num_allocators-1:0]     alloc_valid,
    output logic [num_allocators-1:0]     alloc_ack,
    input  logic [48*num_allocators-1:0]  alloc_result,
    input  logic [8*num_allocators-1:0]   alloc_x,
    input  logic [8*num_allocators-1:0]   alloc_y,
    input  logic [7:0]                    image_dim,
    input  logic [2:0]                    filter_stride,
    input  logic [5:0]                    result_shift,
    input  logic                          relu_en,
    input  logic [15:0]                   out_plane_base,
    input  logic                          issue_done,
    output logic [15:0]                   omem_write_addr,
    output logic [17:0]                   omem_write_data,
    output logic                          omem_write_en,
    output logic                          busy,
    output logic                          stride_error,
    output logic                          done
);

    localparam int PTR_W = (num_allocators > 1) ? $clog2(num_allocators) : 1;

    logic [PTR_W-1:0]          ptr_q, ptr_d;
    logic [num_allocators-1:0] ack_q, ack_d;
    logic [num_allocators-1:0] cand;
    logic                      grant;
    logic                      found_hi;
    logic [PTR_W-1:0]          idx_hi, idx_lo, gnt_idx;

    logic                      stride_legal;
    logic [1:0]                stride_shift;

    logic                      s1_valid_q;
    logic                      s1_legal_q;
    logic [1:0]                s1_shift_q;
    logic [47:0]               s1_result_q;
    logic [7:0]                s1_x_q, s1_y_q;

    logic signed [47:0]        shifted;
    logic [17:0]               data_d;
    logic [15:0]               addr_d;
    logic [7:0]                out_dim, ox, oy;
    logic                      wr_en_d;
    logic                      done_d;

    // The ack register doubles as the one-cycle mask: an allocator acked this cycle still shows
    // valid until it samples the ack, so it must not be granted a second time.
    always_comb begin
        cand     = alloc_valid & ~ack_q;
        found_hi = 1'b0;
        grant    = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int j = num_allocators - 1; j >= 0; j--) begin
            if (cand[j]) begin
                grant  = 1'b1;
                idx_lo = PTR_W'(j);
                if (j >= int'(ptr_q)) begin
                    found_hi = 1'b1;
                    idx_hi   = PTR_W'(j);
                end
            end
        end
        gnt_idx = found_hi ? idx_hi : idx_lo;

        ptr_d = ptr_q;
        ack_d = '0;
        if (grant) begin
            ack_d[gnt_idx] = 1'b1;
            ptr_d = (int'(gnt_idx) == num_allocators - 1) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    always_comb begin
        stride_legal = 1'b1;
        stride_shift = 2'd0;
        case (filter_stride)
            3'd1:    stride_shift = 2'd0;
            3'd2:    stride_shift = 2'd1;
            3'd4:    stride_shift = 2'd2;
            default: stride_legal = 1'b0;
        endcase
    end

    always_comb begin
        shifted = $signed(s1_result_q) >>> result_shift;
        if (relu_en && shifted < 0) begin
            shifted = '0;
        end
        if (shifted > 48'sd131071) begin
            data_d = 18'h1FFFF;
        end else if (shifted < -48'sd131072) begin
            data_d = 18'h20000;
        end else begin
            data_d = shifted[17:0];
        end

        out_dim = image_dim >> s1_shift_q;
        ox      = s1_x_q >> s1_shift_q;
        oy      = s1_y_q >> s1_shift_q;
        addr_d  = out_plane_base + 16'(oy) * 16'(out_dim) + 16'(ox);
        wr_en_d = s1_valid_q & s1_legal_q;
    end

    assign busy   = (|alloc_valid) | s1_valid_q | omem_write_en;
    assign done_d = done | (issue_done & ~busy);

    // Stage 1 captures the granted allocator's payload; the output stage registers the write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q           <= '0;
            ack_q           <= '0;
            s1_valid_q      <= 1'b0;
            s1_legal_q      <= 1'b0;
            s1_shift_q      <= '0;
            s1_result_q     <= '0;
            s1_x_q          <= '0;
            s1_y_q          <= '0;
            omem_write_en   <= 1'b0;
            omem_write_addr <= '0;
            omem_write_data <= '0;
            stride_error    <= 1'b0;
            done            <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            ack_q      <= ack_d;
            s1_valid_q <= grant;
            if (grant) begin
                s1_legal_q  <= stride_legal;
                s1_shift_q  <= stride_shift;
                s1_result_q <= alloc_result[48*gnt_idx +: 48];
                s1_x_q      <= alloc_x[8*gnt_idx +: 8];
                s1_y_q      <= alloc_y[8*gnt_idx +: 8];
                if (!stride_legal) begin
                    stride_error <= 1'b1;
                end
            end
            omem_write_en <= wr_en_d;
            if (wr_en_d) begin
                omem_write_addr <= addr_d;
                omem_write_data <= data_d;
            end
            done <= done_d;
        end
    end

    assign alloc_ack = ack_q;

endmodule

// File: tb/tb_conv_result_collector.sv
// Directed bench for conv_result_collector: a vector table for the datapath, plus cycle-by-cycle
// sequences for round-robin order, wrap, done and mid-pipeline reset.
module tb_conv_result_collector;

    localparam int N = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    alloc_valid;
    logic [N-1:0]    alloc_ack;
    logic [48*N-1:0] alloc_result;
    logic [8*N-1:0]  alloc_x, alloc_y;
    logic [7:0]      image_dim;
    logic [2:0]      filter_stride;
    logic [5:0]      result_shift;
    logic            relu_en;
    logic [15:0]     out_plane_base;
    logic            issue_done;
    logic [15:0]     omem_write_addr;
    logic [17:0]     omem_write_data;
    logic            omem_write_en;
    logic            busy, stride_error, done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          idx;
        logic [47:0] result;
        logic [7:0]  x, y, dim;
        logic [2:0]  stride;
        logic [5:0]  shift;
        logic        relu;
        logic [15:0] base;
        logic        expWe;
        logic [15:0] expAddr;
        logic [17:0] expData;
    } vec_t;

    vec_t vecs[8];

    logic [N-1:0] expAck[6];
    logic         expWe[6];
    logic [15:0]  expAddr[6];
    logic [17:0]  expData[6];
    logic         expBusy[6];
    logic         expDone[6];

    conv_result_collector #(.num_allocators(N)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ack(alloc_ack),
        .alloc_result(alloc_result), .alloc_x(alloc_x), .alloc_y(alloc_y),
        .image_dim(image_dim), .filter_stride(filter_stride), .result_shift(result_shift),
        .relu_en(relu_en), .out_plane_base(out_plane_base), .issue_done(issue_done),
        .omem_write_addr(omem_write_addr), .omem_write_data(omem_write_data),
        .omem_write_en(omem_write_en), .busy(busy), .stride_error(stride_error), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Plays one allocator: raise valid, wait for the ack, drop valid after sampling it.
    task automatic applyStimulus(input vec_t v, input int id);
        int waited = 0;
        @(negedge clk);
        image_dim      = v.dim;
        filter_stride  = v.stride;
        result_shift   = v.shift;
        relu_en        = v.relu;
        out_plane_base = v.base;
        alloc_result[48*v.idx +: 48] = v.result;
        alloc_x[8*v.idx +: 8] = v.x;
        alloc_y[8*v.idx +: 8] = v.y;
        alloc_valid[v.idx] = 1'b1;
        while (waited < 8) begin
            @(posedge clk); #1;
            waited++;
            if (alloc_ack != '0) break;
        end
        checkOutput($sformatf("vec%0d.ackLatency", id), 48'(waited), 48'd1);
        checkOutput($sformatf("vec%0d.ack", id), 48'(alloc_ack), 48'(1) << v.idx);
        @(posedge clk); #1;
        alloc_valid[v.idx] = 1'b0;
        checkOutput($sformatf("vec%0d.ackPulse", id), 48'(alloc_ack), 48'd0);
        checkOutput($sformatf("vec%0d.we", id), 48'(omem_write_en), 48'(v.expWe));
        if (v.expWe) begin
            checkOutput($sformatf("vec%0d.addr", id), 48'(omem_write_addr), 48'(v.expAddr));
            checkOutput($sformatf("vec%0d.data", id), 48'(omem_write_data), 48'(v.expData));
        end
        @(posedge clk); #1;
        checkOutput($sformatf("vec%0d.singleWrite", id), 48'(omem_write_en), 48'd0);
    endtask

    // Cycle-by-cycle check against the exp* tables, with allocators dropping valid a cycle after ack.
    task automatic runSequence(input string tag);
        logic [N-1:0] pending = '0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            alloc_valid = alloc_valid & ~pending;
            pending = alloc_ack;
            checkOutput($sformatf("%s.ack[%0d]", tag, k), 48'(alloc_ack), 48'(expAck[k]));
            checkOutput($sformatf("%s.we[%0d]", tag, k), 48'(omem_write_en), 48'(expWe[k]));
            if (expWe[k]) begin
                checkOutput($sformatf("%s.addr[%0d]", tag, k), 48'(omem_write_addr), 48'(expAddr[k]));
                checkOutput($sformatf("%s.data[%0d]", tag, k), 48'(omem_write_data), 48'(expData[k]));
            end
            checkOutput($sformatf("%s.busy[%0d]", tag, k), 48'(busy), 48'(expBusy[k]));
            checkOutput($sformatf("%s.done[%0d]", tag, k), 48'(done), 48'(expDone[k]));
        end
        alloc_valid = alloc_valid & ~pending;
    endtask

    initial begin
        int waited;

        rst = 1'b1;
        alloc_valid = '0;
        alloc_result = '0;
        alloc_x = '0;
        alloc_y = '0;
        image_dim = 8'd16;
        filter_stride = 3'd1;
        result_shift = '0;
        relu_en = 1'b0;
        out_plane_base = '0;
        issue_done = 1'b0;

        vecs[0] = '{3, 48'h0000_0000_1000, 8'd10,  8'd4,   8'd13,  3'd1, 6'd4, 1'b0, 16'h0000, 1'b1, 16'd62,   18'd256};
        vecs[1] = '{2, 48'h0100_0000_0000, 8'd0,   8'd0,   8'd16,  3'd1, 6'd0, 1'b0, 16'h0000, 1'b1, 16'd0,    18'h1FFFF};
        vecs[2] = '{4, 48'hFF00_0000_0000, 8'd0,   8'd0,   8'd16,  3'd1, 6'd0, 1'b0, 16'h0000, 1'b1, 16'd0,    18'h20000};
        vecs[3] = '{4, 48'hFF00_0000_0000, 8'd0,   8'd0,   8'd16,  3'd1, 6'd0, 1'b1, 16'h0000, 1'b1, 16'd0,    18'd0};
        vecs[4] = '{6, 48'hFFFF_FFFF_FFFB, 8'd1,   8'd1,   8'd16,  3'd1, 6'd1, 1'b0, 16'h0000, 1'b1, 16'd17,   18'h3FFFD};
        vecs[5] = '{1, 48'd100,            8'd200, 8'd100, 8'd224, 3'd4, 6'd0, 1'b0, 16'h1000, 1'b1, 16'h15AA, 18'd100};
        vecs[6] = '{0, 48'h0000_0000_07FF, 8'd7,   8'd9,   8'd20,  3'd2, 6'd2, 1'b1, 16'hFFF0, 1'b1, 16'h001B, 18'd511};
        vecs[7] = '{5, 48'd123,            8'd3,   8'd3,   8'd16,  3'd3, 6'd0, 1'b0, 16'h0000, 1'b0, 16'd0,    18'd0};

        repeat (2) @(negedge clk);
        checkOutput("reset.ack", 48'(alloc_ack), 48'd0);
        checkOutput("reset.we", 48'(omem_write_en), 48'd0);
        checkOutput("reset.done", 48'(done), 48'd0);
        rst = 1'b0;

        $display("[TB] datapath vectors");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], i);
        end
        checkOutput("strideErrorSticky", 48'(stride_error), 48'd1);

        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst.strideError", 48'(stride_error), 48'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] round-robin 0,1,5");
        filter_stride = 3'd1;
        image_dim = 8'd16;
        result_shift = '0;
        relu_en = 1'b0;
        out_plane_base = '0;
        for (int i = 0; i < N; i++) begin
            alloc_result[48*i +: 48] = 48'(100 + i);
            alloc_x[8*i +: 8] = 8'(i);
            alloc_y[8*i +: 8] = 8'd0;
        end
        alloc_valid = 8'b0010_0011;
        expAck  = '{8'h01, 8'h02, 8'h20, 8'h00, 8'h00, 8'h00};
        expWe   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        expAddr = '{16'd0, 16'd0, 16'd1, 16'd5, 16'd0, 16'd0};
        expData = '{18'd0, 18'd100, 18'd101, 18'd105, 18'd0, 18'd0};
        expBusy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        expDone = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        runSequence("rr");

        $display("[TB] pointer wrap");
        @(negedge clk);
        alloc_valid = 8'b1000_0001;
        expAck  = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
        expWe   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        expAddr = '{16'd0, 16'd7, 16'd0, 16'd0, 16'd0, 16'd0};
        expData = '{18'd0, 18'd107, 18'd100, 18'd0, 18'd0, 18'd0};
        expBusy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        runSequence("wrap");

        $display("[TB] done with results in flight");
        @(negedge clk);
        alloc_valid = 8'b0000_1100;
        issue_done = 1'b1;
        expAck  = '{8'h04, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
        expWe   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        expAddr = '{16'd0, 16'd2, 16'd3, 16'd0, 16'd0, 16'd0};
        expData = '{18'd0, 18'd102, 18'd103, 18'd0, 18'd0, 18'd0};
        expBusy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        expDone = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        runSequence("done");

        $display("[TB] reset mid-pipeline");
        @(negedge clk);
        alloc_valid = 8'b0101_0000;
        @(posedge clk); #1;
        checkOutput("mid.ack4", 48'(alloc_ack), 48'h10);
        @(posedge clk); #1;
        alloc_valid[4] = 1'b0;
        checkOutput("mid.ack6", 48'(alloc_ack), 48'h40);
        checkOutput("mid.we", 48'(omem_write_en), 48'd1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async.we", 48'(omem_write_en), 48'd0);
        checkOutput("async.ack", 48'(alloc_ack), 48'd0);
        checkOutput("async.done", 48'(done), 48'd0);
        checkOutput("async.busy", 48'(busy), 48'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        waited = 0;
        while (waited < 8) begin
            @(posedge clk); #1;
            waited++;
            if (alloc_ack != '0) break;
        end
        checkOutput("recollect.ack", 48'(alloc_ack), 48'h40);
        @(posedge clk); #1;
        alloc_valid[6] = 1'b0;
        checkOutput("recollect.we", 48'(omem_write_en), 48'd1);
        checkOutput("recollect.addr", 48'(omem_write_addr), 48'd6);
        checkOutput("recollect.data", 48'(omem_write_data), 48'd106);
        @(posedge clk); #1;
        checkOutput("recollect.busy", 48'(busy), 48'd0);
        checkOutput("recollect.doneWait", 48'(done), 48'd0);
        @(posedge clk); #1;
        checkOutput("recollect.done", 48'(done), 48'd1);
        checkOutput("recollect.strideError", 48'(stride_error), 48'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
